// File: rtl/mandelbrot_iter_engine_if.sv
// Handshake bundle between the coordinate mapper, the escape-time engine and
// the frame RAM.
//   mapper -> engine : in_valid, c_re, c_im, x_in, y_in   (engine drives in_ready)
//   engine -> RAM    : out_valid, count_out, x_out, y_out (RAM drives out_ready)
//   busy             : engine status, high whenever a pixel is in flight
// The engine connects through the slave modport; the mapper/RAM side
// (or a testbench) uses master.
interface mandelbrot_iter_engine_if #(
  parameter int DW = 32,
  parameter int CW = 8,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] c_re;
  logic signed [DW-1:0] c_im;
  logic [XW-1:0]        x_in;
  logic [YW-1:0]        y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        count_out;
  logic [XW-1:0]        x_out;
  logic [YW-1:0]        y_out;
  logic                 busy;

  modport slave (
    input  in_valid, c_re, c_im, x_in, y_in, out_ready,
    output in_ready, out_valid, count_out, x_out, y_out, busy
  );

  modport master (
    output in_valid, c_re, c_im, x_in, y_in, out_ready,
    input  in_ready, out_valid, count_out, x_out, y_out, busy
  );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// Per-pixel Mandelbrot escape-time engine.
// Takes one complex c (Q(DW-FRAC).FRAC) tagged with (x, y), iterates
// z = z^2 + c from z = 0 until |z|^2 > 4 or MAX_ITER, then presents the
// iteration count with its tag until the consumer accepts it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : mandelbrot_iter_engine_if.slave (input handshake + c/x/y,
//          output handshake + count/x/y, busy)
// One pixel in flight; in_ready only in IDLE.
module mandelbrot_iter_engine #(
  parameter int DW       = 32,
  parameter int FRAC     = 28,
  parameter int MAX_ITER = 255,
  parameter int CW       = 8,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  mandelbrot_iter_engine_if.slave  bus
);

  localparam int PW = 2 * DW;   // full product width
  localparam int WW = DW + 4;   // widened width for squares/magnitude (|z|^2 up to ~47)
  localparam logic signed [WW-1:0] LIM = WW'(1) << (FRAC + 2);  // 4.0

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t               r_state, w_next;
  logic signed [DW-1:0] r_cre, r_cim, r_zr, r_zi;
  logic [XW-1:0]        r_x, r_xo;
  logic [YW-1:0]        r_y, r_yo;
  logic [CW-1:0]        r_n, r_count;
  logic                 r_ovalid;
  logic                 r_prime;

  logic signed [PW-1:0] w_ezr, w_ezi, w_pzr, w_pzi, w_pzri;
  logic signed [WW-1:0] w_zr2, w_zi2, w_zri, w_mag;
  logic signed [DW-1:0] w_zr_nx, w_zi_nx;
  logic                 w_accept, w_escape, w_finish, w_hs;

  // Datapath: full-width products, arithmetic shift, keep WW bits so the
  // integer part of |z|^2 is never lost before the compare.
  assign w_ezr   = {{DW{r_zr[DW-1]}}, r_zr};
  assign w_ezi   = {{DW{r_zi[DW-1]}}, r_zi};
  assign w_pzr   = w_ezr * w_ezr;
  assign w_pzi   = w_ezi * w_ezi;
  assign w_pzri  = w_ezr * w_ezi;
  assign w_zr2   = WW'(w_pzr  >>> FRAC);
  assign w_zi2   = WW'(w_pzi  >>> FRAC);
  assign w_zri   = WW'(w_pzri >>> FRAC);
  assign w_mag   = w_zr2 + w_zi2;
  assign w_escape = (w_mag > LIM);
  assign w_finish = w_escape || (r_n == CW'(MAX_ITER));
  // Pre-update |z| <= 2 and |c| in range keep these within DW.
  assign w_zr_nx = DW'(w_zr2 - w_zi2) + r_cre;
  assign w_zi_nx = DW'(w_zri <<< 1) + r_cim;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_hs     = bus.out_ready && (r_state == S_DONE);

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_ovalid;
  assign bus.count_out = r_count;
  assign bus.x_out     = r_xo;
  assign bus.y_out     = r_yo;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ITER;
      S_ITER:  if (!r_prime && w_finish) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cre    <= '0;
      r_cim    <= '0;
      r_zr     <= '0;
      r_zi     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_xo     <= '0;
      r_yo     <= '0;
      r_n      <= '0;
      r_count  <= '0;
      r_ovalid <= 1'b0;
      r_prime  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cre   <= bus.c_re;
        r_cim   <= bus.c_im;
        r_x     <= bus.x_in;
        r_y     <= bus.y_in;
        r_zr    <= '0;
        r_zi    <= '0;
        r_n     <= '0;
        r_prime <= 1'b1;
      end
      if (r_state == S_ITER) begin
        // The first ITER cycle is a settle cycle for the freshly loaded
        // operands; the n=0 check happens on the next one, which makes the
        // result appear count+2 edges after the accept.
        if (r_prime) begin
          r_prime <= 1'b0;
        end else if (w_finish) begin
          r_count  <= r_n;
          r_xo     <= r_x;
          r_yo     <= r_y;
          r_ovalid <= 1'b1;
        end else begin
          r_zr <= w_zr_nx;
          r_zi <= w_zi_nx;
          r_n  <= r_n + CW'(1);
        end
      end
      if (w_hs) r_ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Self-checking bench for mandelbrot_iter_engine: directed cases from the
// behaviour description plus randomized pixels checked against an integer
// escape-time model.
module tb_mandelbrot_iter_engine;
  localparam int DW = 32, FRAC = 28, MAX_ITER = 255, CW = 8, XW = 10, YW = 10;
  localparam logic signed [31:0] ONE  = 32'sh1000_0000;
  localparam logic signed [31:0] TWO  = 32'sh2000_0000;
  localparam logic signed [31:0] MTWO = -32'sh2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mandelbrot_iter_engine_if #(.DW(DW), .CW(CW), .XW(XW), .YW(YW)) bus();

  mandelbrot_iter_engine #(
    .DW(DW), .FRAC(FRAC), .MAX_ITER(MAX_ITER), .CW(CW), .XW(XW), .YW(YW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Escape-time reference: plain 64-bit fixed-point arithmetic.
  function automatic int model_count(input logic signed [31:0] cr, input logic signed [31:0] ci);
    longint zr = 0, zi = 0, zr2, zi2, zri;
    longint lim = longint'(4) <<< FRAC;
    for (int n = 0; n <= MAX_ITER; n++) begin
      zr2 = (zr * zr) >>> FRAC;
      zi2 = (zi * zi) >>> FRAC;
      zri = (zr * zi) >>> FRAC;
      if ((zr2 + zi2) > lim || n == MAX_ITER) return n;
      zr = longint'(int'(zr2 - zi2 + longint'(cr)));
      zi = longint'(int'((zri <<< 1) + longint'(ci)));
    end
    return MAX_ITER;
  endfunction

  // Drive a pixel and wait for the accepting edge; returns #1 after it.
  task automatic accept_px(input logic signed [31:0] cr, input logic signed [31:0] ci,
                           input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input bit keep, output bit ok);
    ok = 1'b0;
    bus.c_re = cr; bus.c_im = ci; bus.x_in = x; bus.y_in = y;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept until out_valid is seen.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.c_re = '0; bus.c_im = '0; bus.x_in = '0; bus.y_in = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.count_out, bus.x_out, bus.y_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ov=%0b cnt=%0d x=%0d y=%0d want all 0",
               bus.out_valid, bus.count_out, bus.x_out, bus.y_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%0b busy=%0b want 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_directed();
    logic signed [31:0] t_cr [5] = '{32'sh0, ONE, TWO, MTWO, 32'sh0};
    logic signed [31:0] t_ci [5] = '{32'sh0, 32'sh0, 32'sh0, 32'sh0, ONE};
    int                 t_n  [5] = '{255, 3, 2, 255, 255};
    int lat; bit ok;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      accept_px(t_cr[k], t_ci[k], XW'(5 + k), YW'(7 + k), 1'b0, ok);
      wait_out(lat, ok);
      n_cmp++;
      if (!ok || bus.count_out !== CW'(t_n[k]) || bus.x_out !== XW'(5 + k) || bus.y_out !== YW'(7 + k)) begin
        n_bad++;
        $display("FAIL directed_%0d: got ok=%0b cnt=%0d x=%0d y=%0d want cnt=%0d x=%0d y=%0d",
                 k, ok, bus.count_out, bus.x_out, bus.y_out, t_n[k], 5 + k, 7 + k);
      end
      n_cmp++;
      if (lat != t_n[k] + 2) begin
        n_bad++;
        $display("FAIL directed_lat_%0d: got %0d want %0d", k, lat, t_n[k] + 2);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_pulse_%0d: got ov=%0b in_ready=%0b want 0/1", k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_hold_off();
    int lat; bit ok; int exp_b;
    bus.out_ready = 1'b1;
    accept_px(32'sh0, ONE, 10'd100, 10'd200, 1'b1, ok);
    // Second pixel presented immediately, in_valid stays high
    bus.c_re = ONE; bus.c_im = 32'sh0; bus.x_in = 10'd300; bus.y_in = 10'd400;
    exp_b = model_count(ONE, 32'sh0);
    for (int i = 0; i < 3; i++) begin
      repeat (20) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_off_ready_%0d: got in_ready=%0b busy=%0b want 0/1", i, bus.in_ready, bus.busy);
      end
    end
    wait_out(lat, ok);
    n_cmp++;
    if (!ok || bus.count_out !== 8'd255 || bus.x_out !== 10'd100 || bus.y_out !== 10'd200) begin
      n_bad++;
      $display("FAIL hold_off_first: got ok=%0b cnt=%0d x=%0d y=%0d want 255/100/200",
               ok, bus.count_out, bus.x_out, bus.y_out);
    end
    accept_px(ONE, 32'sh0, 10'd300, 10'd400, 1'b0, ok);
    wait_out(lat, ok);
    n_cmp++;
    if (!ok || bus.count_out !== CW'(exp_b) || bus.x_out !== 10'd300 || bus.y_out !== 10'd400 || lat != exp_b + 2) begin
      n_bad++;
      $display("FAIL hold_off_second: got ok=%0b cnt=%0d x=%0d y=%0d lat=%0d want %0d/300/400 lat %0d",
               ok, bus.count_out, bus.x_out, bus.y_out, lat, exp_b, exp_b + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    bus.out_ready = 1'b0;
    accept_px(ONE, 32'sh0, 10'd3, 10'd9, 1'b0, ok);
    wait_out(lat, ok);
    n_cmp++;
    if (!ok || lat != 5) begin
      n_bad++;
      $display("FAIL bp_latency: got ok=%0b lat=%0d want 5", ok, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.out_valid, bus.count_out, bus.x_out, bus.y_out} !== {1'b1, 8'd3, 10'd3, 10'd9}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got ov=%0b cnt=%0d x=%0d y=%0d want 1/3/3/9",
                 i, bus.out_valid, bus.count_out, bus.x_out, bus.y_out);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got ov=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok;
    bus.out_ready = 1'b1;
    accept_px(32'sh0, 32'sh0, 10'd11, 10'd12, 1'b0, ok);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_cmp++;
    if ({bus.out_valid, bus.count_out, bus.x_out, bus.y_out} !== '0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: got ov=%0b cnt=%0d x=%0d y=%0d in_ready=%0b want 0/0/0/0/1",
               bus.out_valid, bus.count_out, bus.x_out, bus.y_out, bus.in_ready);
    end
    accept_px(ONE, 32'sh0, 10'd1, 10'd2, 1'b0, ok);
    wait_out(lat, ok);
    n_cmp++;
    if (!ok || bus.count_out !== 8'd3 || bus.x_out !== 10'd1 || bus.y_out !== 10'd2 || lat != 5) begin
      n_bad++;
      $display("FAIL reset_mid_next: got ok=%0b cnt=%0d x=%0d y=%0d lat=%0d want 3/1/2 lat 5",
               ok, bus.count_out, bus.x_out, bus.y_out, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, exp_n, stall; bit ok;
    logic signed [31:0] cr, ci;
    logic [XW-1:0] x; logic [YW-1:0] y;
    for (int k = 0; k < 16; k++) begin
      cr = $signed($urandom_range(0, 32'h4000_0000)) - TWO;
      ci = $signed($urandom_range(0, 32'h4000_0000)) - TWO;
      x  = XW'($urandom); y = YW'($urandom);
      exp_n = model_count(cr, ci);
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      accept_px(cr, ci, x, y, 1'b0, ok);
      wait_out(lat, ok);
      n_cmp++;
      if (!ok || bus.count_out !== CW'(exp_n) || bus.x_out !== x || bus.y_out !== y || lat != exp_n + 2) begin
        n_bad++;
        $display("FAIL random_%0d: c=(%h,%h) got ok=%0b cnt=%0d x=%0d y=%0d lat=%0d want %0d/%0d/%0d lat %0d",
                 k, cr, ci, ok, bus.count_out, bus.x_out, bus.y_out, lat, exp_n, x, y, exp_n + 2);
      end
      repeat (stall) @(posedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_off();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter_engine.md
Name: mandelbrot_iter_engine

Overview:
Per-pixel Mandelbrot escape-time engine. Accepts one complex coordinate c, tagged with its pixel position (x, y), from the coordinate mapper. It iterates z = z² + c from z = 0 until |z|² > 4 or MAX_ITER is reached. It then presents the iteration count with the same (x, y) tag downstream; the frame RAM writes count_out at address {y_out, x_out} while out_valid is high.

Parameters:
DW, 32, signed fixed-point width of c and z (two's complement, Q(DW-FRAC).FRAC)
FRAC, 28, fractional bits (default Q4.28, range [-8, 8))
MAX_ITER, 255, iteration cap; count saturates here
CW, 8, count_out width; must hold MAX_ITER
XW, 10, x coordinate width
YW, 10, y coordinate width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
in_valid  input  1  mapper presents c/x/y
in_ready  output  1  engine can accept (high only in IDLE)
c_re  input  DW  real part of c, |c_re| <= 2.0
c_im  input  DW  imaginary part of c, |c_im| <= 2.0
x_in  input  XW  pixel column tag
y_in  input  YW  pixel row tag
out_valid  output  1  result available
out_ready  input  1  RAM/consumer accepts result
count_out  output  CW  escape iteration count
x_out  output  XW  column tag of result
y_out  output  YW  row tag of result
busy  output  1  state != IDLE

Behaviour:
- Reset: rst=0 at a rising edge forces IDLE. Clears out_valid, count_out, x_out, y_out, z, n to 0. Applies in any state; an in-flight pixel is discarded with no partial output. in_ready=1 from the first cycle after rst returns high.
- States: IDLE, ITER, DONE. in_ready = (state==IDLE); busy = (state!=IDLE). Both are combinational from state.
- IDLE: when in_valid && in_ready at an edge, register c_re, c_im, x_in, y_in, set zr=zi=0, n=0, and go to ITER. in_valid is ignored in any other state.
- ITER, every cycle:
  - zr2 = (zr*zr)>>>FRAC, zi2 = (zi*zi)>>>FRAC, zri = (zr*zi)>>>FRAC.
  - Form the full 2*DW products, arithmetic-shift them, and keep at least DW+4 bits. No integer-part truncation is allowed: |z| before a check can reach about 6.83, so |z|² can reach about 46.6.
  - mag = zr2 + zi2, compared against 4<<FRAC in the widened width. The escape condition is strictly mag > 4.0.
  - If escape or n == MAX_ITER: count_out <= n, x_out/y_out <= tags, out_valid <= 1, go to DONE.
  - Otherwise: zr <= zr2 - zi2 + c_re, zi <= (zri<<1) + c_im (truncated to DW; these cannot overflow given |c| <= 2 and |z| <= 2 pre-update), n <= n+1.
- Latency: out_valid rises at the edge that is count_out+2 cycles after the accepting edge. Worst case is MAX_ITER+2.
- DONE: out_valid, count_out, x_out and y_out are held stable until out_ready=1 at an edge. That handshake clears out_valid and returns to IDLE.
- Throughput is one pixel in flight. The next accept happens no earlier than the cycle after the output handshake.
- If out_ready is high before DONE, it has no effect. out_valid never drops without a handshake except on reset.
- Inputs with |c| > 2 are out of contract; behaviour is unspecified but must not hang. The MAX_ITER cap guarantees termination.

Test Plan:
- c=(0,0), x=5, y=7, out_ready=1: count_out=255, x_out=5, y_out=7. out_valid rises 257 cycles after accept, high for 1 cycle.
- c=(1.0,0): z sequence 0,1,2,5. mag=4 does not escape; mag=25 does. Result count_out=3, out_valid at accept+5.
- c=(2.0,0): count_out=2, latency 4. c=(-2.0,0): z oscillates at 2, mag=4 never >4, count_out=255.
- c=(0,1.0) (periodic orbit, max mag 2) gives count_out=255. in_valid held high during ITER shows in_ready=0 and a second pixel is not accepted until after the output handshake.
- Backpressure: out_ready=0 for 5 cycles in DONE. out_valid, count_out and the tags stay constant. out_ready=1 completes the handshake and in_ready=1 on the next cycle.
- Reset mid-ITER (rst=0 for 1 cycle at iteration 10 of c=(0,0)): out_valid=0, count_out/x_out/y_out=0, in_ready=1 after release. A new pixel c=(1.0,0) then returns count_out=3.
